// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
//   Shared definitions for the PS/2 host-to-device transmit path:
//   FSM state encoding, frame length, common keyboard command bytes and
//   a helper that assembles the serial frame for a command byte.
// ----------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAITIDLE,
        DONE,
        ERR
    } state_t;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ECHO    = 8'hEE;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    // Frame as shifted out LSB first: bit 0 is the start bit (0), then the
    // data byte, odd parity and the stop bit (1).
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
        return {1'b1, ~^data, data, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ----------------------------------------------------------------------------
// ps2_line_filter
//   Brings an asynchronous PS/2 line into the iClk domain through a 2-FF
//   synchronizer, then accepts a new level only after FILTER_LEN consecutive
//   equal synchronized samples. Shared by the transmit and receive paths.
// Ports
//   iClk    in   system clock
//   iReset  in   synchronous reset, active-high (line assumed idle high)
//   iPin    in   raw line level
//   oLevel  out  filtered line level
//   oFall   out  one-cycle pulse when oLevel goes 1 -> 0
// ----------------------------------------------------------------------------
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic iClk,
    input  logic iReset,
    input  logic iPin,
    output logic oLevel,
    output logic oFall
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_fall;
    logic [CNT_W-1:0] r_cnt;

    // NOTE: every register here uses non-blocking assignment so each one
    // samples the values from before the edge; blocking would collapse the
    // two synchronizer stages into one.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= iPin;
            r_sync2 <= r_sync1;
            r_fall  <= 1'b0;
            if (r_sync2 == r_level) begin
                // any sample agreeing with the current level restarts the run
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_fall  <= r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign oLevel = r_level;
    assign oFall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// ----------------------------------------------------------------------------
// ps2_host_tx
//   PS/2 host-to-device transmitter. Holds the clock low to request-to-send,
//   presents the start bit, then shifts data, odd parity and stop on the
//   device-generated clock and checks the device ACK. Pins are open-drain:
//   an Oe of 1 pulls the line low, 0 releases it.
// Ports
//   iClk        in   system clock
//   iReset      in   synchronous reset, active-high
//   iStart      in   one-cycle send request, accepted only while idle
//   iData[7:0]  in   command byte, captured on the accepting cycle
//   iPs2Clk     in   raw PS/2 clock pin level
//   iPs2Data    in   raw PS/2 data pin level
//   oPs2ClkOe   out  pull PS/2 clock low
//   oPs2DataOe  out  pull PS/2 data low
//   oBusy       out  transfer in progress (through the done/error cycle)
//   oDone       out  one-cycle pulse: byte sent and acknowledged
//   oError      out  one-cycle pulse: timeout or missing ACK
// ----------------------------------------------------------------------------
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       iClk,
    input  logic       iReset,
    input  logic       iStart,
    input  logic [7:0] iData,
    input  logic       iPs2Clk,
    input  logic       iPs2Data,
    output logic       oPs2ClkOe,
    output logic       oPs2DataOe,
    output logic       oBusy,
    output logic       oDone,
    output logic       oError
);

    localparam int INH_W  = $clog2(INHIBIT_CYCLES);
    localparam int TOUT_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [INH_W-1:0]  INH_PRE_LAST = INH_W'(INHIBIT_CYCLES - 2);
    localparam logic [INH_W-1:0]  INH_LAST     = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TOUT_W-1:0] TOUT_LAST    = TOUT_W'(TIMEOUT_CYCLES - 1);
    // bit counter value before the edge that puts the stop bit on the line
    localparam logic [3:0]        STOP_PREV    = 4'(FRAME_BITS - 2);
    localparam logic [3:0]        ACK_EDGE     = 4'(FRAME_BITS);

    state_t                  r_state;
    logic [FRAME_BITS-1:0]   r_shift;
    logic [3:0]              r_bit_cnt;
    logic [INH_W-1:0]        r_inh_cnt;
    logic [TOUT_W-1:0]       r_tout_cnt;
    logic                    r_clk_oe;
    logic                    r_data_oe;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_error;
    logic                    r_data_s1;
    logic                    r_data_s2;

    logic                    w_clk_level;
    logic                    w_clk_fall;
    logic                    w_tout_active;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .iClk   (iClk),
        .iReset (iReset),
        .iPin   (iPs2Clk),
        .oLevel (w_clk_level),
        .oFall  (w_clk_fall)
    );

    assign w_tout_active = (r_state == RTS) || (r_state == SEND) ||
                           (r_state == ACK) || (r_state == WAITIDLE);

    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_inh_cnt  <= '0;
            r_tout_cnt <= '0;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_data_s1  <= 1'b1;
            r_data_s2  <= 1'b1;
        end else begin
            // data only needs synchronizing: it is sampled once, well after
            // the filtered clock edge, so no debounce is required
            r_data_s1 <= iPs2Data;
            r_data_s2 <= r_data_s1;
            r_done    <= 1'b0;
            r_error   <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (iStart) begin
                        r_shift   <= build_frame(iData);
                        r_bit_cnt <= '0;
                        r_inh_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_clk_oe  <= 1'b1;
                        r_state   <= INHIBIT;
                    end
                end

                INHIBIT: begin
                    r_inh_cnt <= r_inh_cnt + INH_W'(1);
                    // start bit goes out one cycle before the clock is
                    // released, so the device sees data low the moment the
                    // clock line floats high
                    if (r_inh_cnt == INH_PRE_LAST) begin
                        r_data_oe <= ~r_shift[0];
                    end
                    if (r_inh_cnt == INH_LAST) begin
                        r_clk_oe   <= 1'b0;
                        r_tout_cnt <= '0;
                        r_state    <= RTS;
                    end
                end

                RTS, SEND: begin
                    r_tout_cnt <= r_tout_cnt + TOUT_W'(1);
                    // each falling edge puts the next frame bit on the line;
                    // the stop bit is a 1, i.e. data released
                    if (w_clk_fall) begin
                        r_data_oe <= ~r_shift[1];
                        r_shift   <= {1'b1, r_shift[FRAME_BITS-1:1]};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        r_state   <= (r_bit_cnt == STOP_PREV) ? ACK : SEND;
                    end
                end

                ACK: begin
                    r_tout_cnt <= r_tout_cnt + TOUT_W'(1);
                    if (w_clk_fall) begin
                        r_bit_cnt <= ACK_EDGE;
                        if (!r_data_s2) begin
                            r_state <= WAITIDLE;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= ERR;
                        end
                    end
                end

                WAITIDLE: begin
                    r_tout_cnt <= r_tout_cnt + TOUT_W'(1);
                    if (w_clk_level && r_data_s2) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end

                DONE, ERR: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end

                default: r_state <= IDLE;
            endcase

            // Timeout overrides whatever the state arm decided this cycle.
            if (w_tout_active && (r_tout_cnt == TOUT_LAST)) begin
                r_clk_oe  <= 1'b0;
                r_data_oe <= 1'b0;
                r_done    <= 1'b0;
                r_error   <= 1'b1;
                r_state   <= ERR;
            end
        end
    end

    assign oPs2ClkOe  = r_clk_oe;
    assign oPs2DataOe = r_data_oe;
    assign oBusy      = r_busy;
    assign oDone      = r_done;
    assign oError     = r_error;

endmodule
